// File: rtl/branch_cond_unit_if.sv
// Request/result channel between a branch issuer and branch_cond_unit.
// The issuer uses the master modport, the unit uses the slave modport.
interface branch_cond_if #(
  parameter int PC_W = 9
);
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      cond;
  logic [PC_W-1:0] pc;
  logic [7:0]      imm8;
  logic            res_valid;
  logic            res_ready;
  logic            taken;
  logic [PC_W-1:0] next_pc;

  modport master (
    output br_valid, cond, pc, imm8, res_ready,
    input  br_ready, res_valid, taken, next_pc
  );

  modport slave (
    input  br_valid, cond, pc, imm8, res_ready,
    output br_ready, res_valid, taken, next_pc
  );
endinterface

// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds ALU status flags, resolves one branch at a time
// (IDLE -> EVAL -> DONE). Optional taken counter: define BRANCH_COND_STATS_EN.
module branch_cond_unit #(
  parameter int PC_W = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          loads,
  input  logic [2:0]    Z_in,
  output logic [2:0]    status,
  output logic [7:0]    taken_cnt,
  branch_cond_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            br_ready_c;
  logic            res_valid_c;

  logic [2:0]      status_q;
  logic [2:0]      cond_q;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      imm_q;
  logic            taken_q;
  logic [PC_W-1:0] next_pc_q;

  logic            flag_z;
  logic            flag_v;
  logic            flag_n;
  logic            cond_met;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] target_pc;

  assign accept = bus.br_valid && br_ready_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EVAL;
      EVAL:    state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    br_ready_c  = 1'b0;
    res_valid_c = 1'b0;
    case (state)
      IDLE:    br_ready_c  = 1'b1;
      DONE:    res_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Flags load in every state; a held result is already latched, so it is unaffected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= 3'b000;
    end else if (loads) begin
      status_q <= Z_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_q <= 3'b000;
      pc_q   <= '0;
      imm_q  <= 8'h00;
    end else if (accept) begin
      cond_q <= bus.cond;
      pc_q   <= bus.pc;
      imm_q  <= bus.imm8;
    end
  end

  assign flag_z = status_q[0];
  assign flag_v = status_q[1];
  assign flag_n = status_q[2];

  always_comb begin
    cond_met = 1'b0;
    case (cond_q)
      3'b000:  cond_met = 1'b1;
      3'b001:  cond_met = flag_z;
      3'b010:  cond_met = !flag_z;
      3'b011:  cond_met = flag_n ^ flag_v;
      3'b100:  cond_met = (flag_n ^ flag_v) | flag_z;
      default: cond_met = 1'b0;
    endcase
  end

  // Sign-extended offset; sums are PC_W wide so the target wraps naturally.
  assign offset    = PC_W'($signed(imm_q));
  assign seq_pc    = pc_q + PC_W'(1);
  assign target_pc = seq_pc + offset;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_q   <= 1'b0;
      next_pc_q <= '0;
    end else if (state == EVAL) begin
      taken_q   <= cond_met;
      next_pc_q <= cond_met ? target_pc : seq_pc;
    end
  end

`ifdef BRANCH_COND_STATS_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'h00;
    end else if ((state == EVAL) && cond_met && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign taken_cnt = cnt_q;
`else
  assign taken_cnt = 8'h00;
`endif

  assign status        = status_q;
  assign bus.br_ready  = br_ready_c;
  assign bus.res_valid = res_valid_c;
  assign bus.taken     = taken_q;
  assign bus.next_pc   = next_pc_q;

endmodule
